// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB master arbiter.
//   apb_state_t  : bus sequencing states (IDLE, SETUP, ACCESS)
//   DEF_*        : default parameter values for the arbiter
//   cnt_width()  : width of the pready wait counter for a given timeout
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  // A disabled watchdog (timeout 0) still gets a 1-bit counter so no
  // zero-width vector is ever declared.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : index where the search starts (highest priority this round)
//   gnt : one-hot winner (all zero when req == 0)
//   idx : binary index of the winner
//   any : at least one request present
// Rotates req right by ptr, takes the lowest set bit, then maps that
// position back into the original index space.
module apb_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W:0]   sum;

  always_comb begin
    // rotated[j] = req[(j + ptr) mod N]
    doubled = {req, req} >> ptr;
    rotated = doubled[N-1:0];
    rot_idx = '0;
    any     = 1'b0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_idx = IDX_W'(i);
        any     = 1'b1;
      end
    end
    // Un-rotate with an explicit wrap so non-power-of-two N works.
    sum = {1'b0, rot_idx} + {1'b0, ptr};
    if (sum >= (IDX_W + 1)'(N)) begin
      sum = sum - (IDX_W + 1)'(N);
    end
    idx = sum[IDX_W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters, round-robin,
// one transfer in flight at a time, with an optional pready watchdog.
//   clk, resetn              : clock, synchronous active-low reset
//   req/req_addr/req_write/req_wdata : per-requester transfer requests
//   gnt                      : one-hot owner of the current transfer
//   done/rsp_rdata/rsp_err   : one-cycle completion and its response
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr : APB bus
//   dbg_state                : current FSM state (apb_state_t encoding)
// Handshake: a requester holds req and its req_* fields steady until it
// sees done for itself, and drops req at that same clock edge. done and
// rsp_* are combinational from the APB slave during ACCESS; everything
// else is registered.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  apb_state_t       state, next_state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] wait_cnt;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             timeout;
  logic             complete;

  apb_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Fires in the (TIMEOUT_CYC+1)th ACCESS cycle; pready wins if both.
  assign timeout   = (TIMEOUT_CYC > 0) && (wait_cnt == CNT_W'(TIMEOUT_CYC));
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    done       = '0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) next_state = SETUP;
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          complete   = 1'b1;
          done       = gnt;
          rsp_rdata  = prdata;
          rsp_err    = pslverr;
          next_state = IDLE;
        end else if (timeout) begin
          complete   = 1'b1;
          done       = gnt;
          rsp_err    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt    <= pick_gnt;
            paddr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            pwdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            pwrite <= req_write[pick_idx];
            psel   <= 1'b1;
            ptr    <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (complete) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            gnt     <= '0;
          end else if (TIMEOUT_CYC > 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NUM_REQ=4, 32-bit, TIMEOUT_CYC=4).
// Stimulus pushes expected completions {done, rsp_err, rsp_rdata} into
// exp_q; a monitor pops and compares whenever done is non-zero.
module tb_apb_master_arbiter;
  import apb_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam int W  = NR + 1 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    req_write;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    gnt, done;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             psel, penable, pwrite;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata, prdata;
  logic             pready, pslverr;
  logic [1:0]       dbg_state;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0]  exp_q[$];
  int            done_cyc_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [NR-1:0] seen_done = '0;
  logic [NR-1:0] pending_rearm = '0;
  int            rearm_budget = 0;

  // Slave configuration (written by the main thread).
  int            slv_wait;
  logic          slv_hang;
  logic          slv_err;
  logic [DW-1:0] slv_rdata;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB slave model ----------------
  initial begin
    int acc_n;
    acc_n = 0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge clk); #2;
      if (psel && penable) begin
        pready = (!slv_hang && acc_n >= slv_wait);
        acc_n++;
      end else begin
        pready = 1'b0;
        acc_n  = 0;
      end
      prdata  = slv_rdata;
      pslverr = slv_err;
    end
  end

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clk);
    seen_done = done;
    if (done != '0) begin
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0)
        check("unexpected_done", {27'd0, done, rsp_err, rsp_rdata}, 64'd0);
      else
        check("done_rsp", {27'd0, done, rsp_err, rsp_rdata}, {27'd0, exp_q.pop_front()});
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  // ---------------- driver tasks ----------------
  // One clock; requesters drop req at the edge that follows their done.
  task automatic tick();
    logic [NR-1:0] dropped;
    @(posedge clk); #1;
    req = req | pending_rearm;
    pending_rearm = '0;
    dropped = req & seen_done;
    req = req & ~seen_done;
    if (dropped != '0 && rearm_budget > 0) begin
      pending_rearm = dropped;
      rearm_budget--;
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic push_exp(input int i, input logic e, input logic [DW-1:0] d);
    logic [NR-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    exp_q.push_back({oh, e, d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  task automatic cfg_slave(input int w, input logic h, input logic e,
                           input logic [DW-1:0] d);
    slv_wait = w; slv_hang = h; slv_err = e; slv_rdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start;
    int base;
    resetn = 1'b0;
    req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    cfg_slave(0, 1'b0, 1'b0, '0);
    repeat (3) tick();

    check("rst_psel",    psel, 0);
    check("rst_penable", penable, 0);
    check("rst_gnt",     gnt, 0);
    check("rst_pwrite",  pwrite, 0);
    check("rst_paddr",   paddr, 0);
    check("rst_pwdata",  pwdata, 0);
    check("rst_done",    done, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_state",   dbg_state, IDLE);
    resetn = 1'b1;
    tick();

    // All four requesting continuously: 0,1,2,3,0,1,2,3, 3 cycles each.
    for (int i = 0; i < NR; i++) set_req(i, 32'h100 + i * 4, 1'b0, '0);
    cfg_slave(0, 1'b0, 1'b0, 32'h0BADF00D);
    for (int k = 0; k < 8; k++) push_exp(k % NR, 1'b0, 32'h0BADF00D);
    base = done_cyc_q.size();
    rearm_budget = 4;
    req = 4'b1111;
    wait_drain("rr_drain", 60);
    check("rr_count", done_cyc_q.size() - base, 8);
    if (done_cyc_q.size() >= base + 8)
      for (int k = 1; k < 8; k++)
        check("rr_spacing", done_cyc_q[base+k] - done_cyc_q[base+k-1], 3);

    // Single read from requester 2 with immediate pready.
    set_req(2, 32'h40, 1'b0, '0);
    cfg_slave(0, 1'b0, 1'b0, 32'hDEADBEEF);
    push_exp(2, 1'b0, 32'hDEADBEEF);
    req[2] = 1'b1;
    start = cyc;
    tick();
    check("rd_psel_c1",    psel, 1);
    check("rd_penable_c1", penable, 0);
    check("rd_gnt",        gnt, 4'b0100);
    check("rd_paddr",      paddr, 32'h40);
    check("rd_pwrite",     pwrite, 0);
    tick();
    check("rd_psel_c2",    psel, 1);
    check("rd_penable_c2", penable, 1);
    wait_drain("rd_drain", 20);
    check("rd_done_cycle", done_cyc_q[$] - start, 2);

    // Write from requester 1, three wait states, slave error.
    set_req(1, 32'h80, 1'b1, 32'h12345678);
    cfg_slave(3, 1'b0, 1'b1, 32'h5555AAAA);
    push_exp(1, 1'b1, 32'h5555AAAA);
    req[1] = 1'b1;
    start = cyc;
    tick();
    check("wr_pwrite", pwrite, 1);
    check("wr_penable_setup", penable, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wr_penable", penable, 1);
      check("wr_paddr",   paddr, 32'h80);
      check("wr_pwdata",  pwdata, 32'h12345678);
      check("wr_gnt",     gnt, 4'b0010);
    end
    wait_drain("wr_drain", 20);
    check("wr_done_cycle", done_cyc_q[$] - start, 5);

    // ptr is now 2: requesters 1 and 3 -> 3 first, then 1.
    set_req(1, 32'h84, 1'b0, '0);
    set_req(3, 32'h8C, 1'b0, '0);
    cfg_slave(0, 1'b0, 1'b0, 32'h13572468);
    push_exp(3, 1'b0, 32'h13572468);
    push_exp(1, 1'b0, 32'h13572468);
    req = 4'b1010;
    wait_drain("ptr2_drain", 30);

    // Watchdog: slave never ready, done on 5th ACCESS cycle.
    set_req(0, 32'hC0, 1'b0, '0);
    cfg_slave(0, 1'b1, 1'b0, 32'hFFFFFFFF);
    push_exp(0, 1'b1, 32'h0);
    req[0] = 1'b1;
    start = cyc;
    wait_drain("to_drain", 30);
    check("to_done_cycle", done_cyc_q[$] - start, 6);
    check("to_state_after", dbg_state, IDLE);

    // Normal arbitration right after a timeout.
    set_req(2, 32'hC8, 1'b0, '0);
    cfg_slave(0, 1'b0, 1'b0, 32'h2468ACE0);
    push_exp(2, 1'b0, 32'h2468ACE0);
    req[2] = 1'b1;
    start = cyc;
    wait_drain("post_to_drain", 20);
    check("post_to_done_cycle", done_cyc_q[$] - start, 2);

    // Reset during ACCESS of requester 3.
    set_req(3, 32'hD0, 1'b0, '0);
    cfg_slave(0, 1'b1, 1'b0, 32'h0);
    req[3] = 1'b1;
    repeat (3) tick();
    check("rst3_in_access", dbg_state, ACCESS);
    resetn = 1'b0;
    req = '0;
    tick();
    check("rst3_psel",    psel, 0);
    check("rst3_penable", penable, 0);
    check("rst3_gnt",     gnt, 0);
    check("rst3_state",   dbg_state, IDLE);
    resetn = 1'b1;
    cfg_slave(0, 1'b0, 1'b0, 32'h0F0F0F0F);
    tick();
    set_req(0, 32'hE0, 1'b0, '0);
    set_req(2, 32'hE8, 1'b0, '0);
    push_exp(0, 1'b0, 32'h0F0F0F0F);
    push_exp(2, 1'b0, 32'h0F0F0F0F);
    req = 4'b0101;
    wait_drain("rst3_after_drain", 30);

    // Abort requester 1 (ptr would be 2); reset must bring ptr back to 0.
    set_req(1, 32'hF0, 1'b0, '0);
    cfg_slave(0, 1'b1, 1'b0, 32'h0);
    req[1] = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    req = '0;
    tick();
    check("rst1_psel", psel, 0);
    resetn = 1'b1;
    cfg_slave(0, 1'b0, 1'b0, 32'h77665544);
    tick();
    push_exp(0, 1'b0, 32'h77665544);
    push_exp(2, 1'b0, 32'h77665544);
    req = 4'b0101;
    wait_drain("rst1_after_drain", 30);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
